carrier_lock_ctrl: RTL and testbench
====================================

// Module: carrier_lock_ctrl
// PURPOSE
//  Sequences the QPSK carrier-sync (Costas) loop around the phase detector.
//  Averages |phase_error| over fixed windows and walks an ACQ->VERIFY->TRACK FSM.
//  Drives loop-filter gain select, loop enable and NCO clear; reports lock.
//  Sits between phase detector output and loop filter / NCO control inputs.
// PARAMETERS
//  WIN_LOG2   8        log2 of samples per averaging window (16..2^12 samples)
//  LOCK_TH    16'd1200 window mean strictly below this = good window
//  UNLOCK_TH  16'd2400 window mean strictly above this = bad window; must be >= LOCK_TH
//  LOCK_CNT   4        consecutive good windows in VERIFY needed to enter TRACK
//  UNLOCK_CNT 3        consecutive bad windows in TRACK needed to drop lock
//  ACQ_TO     64       windows in ACQ before NCO restart (CSYNC_TIMEOUT_EN only)
// PORTS
//  sys_clk      in  1   system clock
//  sys_rst_n    in  1   async active-low reset
//  start        in  1   level; 1 = run loop, 0 = force IDLE
//  phase_error  in  16  signed two's-complement detector output
//  pe_valid     in  1   phase_error sample strobe
//  loop_en      out 1   loop filter/NCO update enable
//  gain_sel     out 2   2=wide(ACQ/IDLE) 1=medium(VERIFY) 0=narrow(TRACK)
//  nco_clr      out 1   single-cycle NCO/loop-filter integrator clear
//  locked       out 1   1 only in TRACK
//  state_o      out 2   IDLE=0 ACQ=1 VERIFY=2 TRACK=3
//  err_mean     out 16  last completed window mean |phase_error|
//  err_mean_vld out 1   single-cycle strobe on each completed window
// BEHAVIOUR
//  Reset: state IDLE, loop_en=0, gain_sel=2, nco_clr=0, locked=0,
//   err_mean=0, err_mean_vld=0, all counters/sums 0.
//  Magnitude: |x|; x=-32768 saturates to 32767. Sum width 16+WIN_LOG2, no overflow.
//  Mean = sum>>WIN_LOG2 (truncate). Window closes on the WIN-th accepted pe_valid;
//   err_mean/err_mean_vld/state update at that same edge (visible next cycle).
//  Samples only accumulate when state != IDLE; pe_valid ignored in IDLE.
//  IDLE: start=1 -> ACQ, nco_clr pulse, window cleared.
//  ACQ: good window -> VERIFY (good_cnt=1); else stay. loop_en=1, gain_sel=2.
//  VERIFY: good window -> good_cnt++; good_cnt reaching LOCK_CNT -> TRACK;
//   non-good window (mean>=LOCK_TH) -> ACQ, no nco_clr. gain_sel=1.
//  TRACK: bad window -> bad_cnt++; bad_cnt reaching UNLOCK_CNT -> ACQ with
//   nco_clr pulse; good window clears bad_cnt; neutral window leaves it unchanged.
//  Entering ACQ from any state clears window sum/count and all window counters.
//  start=0 in any non-IDLE state -> IDLE next edge, nco_clr pulse, loop_en=0;
//   overrides a window closing the same cycle (that window discarded, no vld).
//  Reset mid-window: everything returns to reset values immediately (async).
// CONFIGURATION
//  CSYNC_TIMEOUT_EN defined: ACQ counts closed windows; on ACQ_TO-th without
//   leaving ACQ -> nco_clr pulse, counter cleared, remain ACQ.
//  Undefined: no timeout counter; ACQ waits indefinitely, nco_clr only on
//   start/unlock/stop events.
// STRUCTURE
//  Shared package/header: state codes, gain_sel codes (GAIN_WIDE/MED/NARROW).
//  Sub-module abs_win_acc: saturating |x|, window counter, sum, mean + done strobe;
//   top holds FSM, lock counters, timeout and output registers.
// TESTING (WIN_LOG2=4, LOCK_CNT=4, UNLOCK_CNT=3, ACQ_TO=8)
//  Reset, start=1, 16 samples pe=+/-500 -> nco_clr pulse on start; err_mean=500, vld, state VERIFY.
//  4 windows of |pe|=500 -> state TRACK, locked=1, gain_sel=0, no nco_clr.
//  In TRACK, 3 windows pe=3000 -> ACQ, nco_clr 1 cycle; 2 bad+1 good+2 bad keeps TRACK.
//  Window of all -32768 -> err_mean=32767 (saturation, no wrap).
//  start=0 on the cycle the 16th sample arrives -> IDLE, nco_clr, no err_mean_vld.
//  CSYNC_TIMEOUT_EN, 8 windows pe=5000 in ACQ -> nco_clr pulse, still ACQ; undefined -> none.

Source files
------------

// File: rtl/carrier_lock_ctrl_pkg.sv
// Shared codes and helpers for the Costas-loop lock sequencer.
// Optional ACQ timeout is enabled with CSYNC_TIMEOUT_EN.
package carrier_lock_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_VERIFY = 2'd2,
        ST_TRACK  = 2'd3
    } state_e;

    localparam logic [1:0] GAIN_WIDE   = 2'd2;
    localparam logic [1:0] GAIN_MED    = 2'd1;
    localparam logic [1:0] GAIN_NARROW = 2'd0;

    localparam int CNT_W = 8;
    localparam int TO_W  = 16;

    // -32768 has no positive twin, so it clamps instead of wrapping
    function automatic logic [15:0] sat_abs(input logic [15:0] x);
        if (x == 16'h8000) return 16'h7fff;
        else if (x[15]) return ~x + 16'd1;
        else return x;
    endfunction

    function automatic logic [1:0] gain_of(input state_e s);
        logic [1:0] g;
        g = GAIN_WIDE;
        unique case (s)
            ST_VERIFY: g = GAIN_MED;
            ST_TRACK:  g = GAIN_NARROW;
            default:   g = GAIN_WIDE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/carrier_lock_ctrl_if.sv
// Detector-side inputs and loop-control outputs of the lock sequencer.
// master drives samples/start, slave is the sequencer.
interface carrier_lock_if;
    logic        start;
    logic [15:0] phase_error;
    logic        pe_valid;
    logic        loop_en;
    logic [1:0]  gain_sel;
    logic        nco_clr;
    logic        locked;
    logic [1:0]  state_o;
    logic [15:0] err_mean;
    logic        err_mean_vld;

    modport master (
        output start, phase_error, pe_valid,
        input  loop_en, gain_sel, nco_clr, locked,
        input  state_o, err_mean, err_mean_vld
    );

    modport slave (
        input  start, phase_error, pe_valid,
        output loop_en, gain_sel, nco_clr, locked,
        output state_o, err_mean, err_mean_vld
    );
endinterface

// File: rtl/carrier_lock_ctrl_abs_win_acc.sv
// Windowed mean of saturated |x|; done/mean are combinational on the
// closing sample so the caller can register them at the same edge.
module abs_win_acc
    import carrier_lock_ctrl_pkg::*;
#(
    parameter int WIN_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] x,
    output logic        done_o,
    output logic [15:0] mean_o
);
    localparam int SW = 16 + WIN_LOG2;

    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [SW-1:0]       sum_q, sum_d, sum_nx;
    logic [15:0]         mag;

    always_comb begin
        mag    = sat_abs(x);
        sum_nx = sum_q + SW'(mag);
        done_o = en && (cnt_q == '1);
        mean_o = 16'(sum_nx >> WIN_LOG2);
        cnt_d  = cnt_q;
        sum_d  = sum_q;
        if (clr) begin
            cnt_d = '0;
            sum_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
            sum_d = done_o ? '0 : sum_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sum_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sum_q <= sum_d;
        end
    end

endmodule

// File: rtl/carrier_lock_ctrl.sv
// ACQ->VERIFY->TRACK sequencer for the QPSK Costas loop.
// Define CSYNC_TIMEOUT_EN to restart the NCO after ACQ_TO idle ACQ windows.
module carrier_lock_ctrl
    import carrier_lock_ctrl_pkg::*;
#(
    parameter int          WIN_LOG2   = 8,
    parameter logic [15:0] LOCK_TH    = 16'd1200,
    parameter logic [15:0] UNLOCK_TH  = 16'd2400,
    parameter int          LOCK_CNT   = 4,
    parameter int          UNLOCK_CNT = 3,
    parameter int          ACQ_TO     = 64
) (
    input logic           sys_clk,
    input logic           sys_rst_n,
    carrier_lock_if.slave bus
);
    if (UNLOCK_TH < LOCK_TH) begin : g_th_chk
        $error("UNLOCK_TH below LOCK_TH");
    end
    if (ACQ_TO < 1) begin : g_to_chk
        $error("ACQ_TO must be positive");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   good_q, good_d;
    logic [CNT_W-1:0]   bad_q, bad_d;
    logic               loop_en_q, loop_en_d;
    logic [1:0]         gain_q, gain_d;
    logic               nco_clr_q, nco_clr_d;
    logic               locked_q, locked_d;
    logic [15:0]        mean_q, mean_d;
    logic               vld_q, vld_d;
`ifdef CSYNC_TIMEOUT_EN
    logic [TO_W-1:0]    to_q, to_d;
`endif

    logic        acc_en, acc_clr, win_done;
    logic [15:0] win_mean;
    logic        good, bad;

    assign acc_en = bus.pe_valid && (state_q != ST_IDLE);

    abs_win_acc #(.WIN_LOG2(WIN_LOG2)) u_acc (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .clr    (acc_clr),
        .en     (acc_en),
        .x      (bus.phase_error),
        .done_o (win_done),
        .mean_o (win_mean)
    );

    assign good = win_mean < LOCK_TH;
    assign bad  = win_mean > UNLOCK_TH;

    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        bad_d     = bad_q;
        nco_clr_d = 1'b0;
        vld_d     = 1'b0;
        mean_d    = mean_q;
        acc_clr   = 1'b0;
`ifdef CSYNC_TIMEOUT_EN
        to_d      = to_q;
`endif
        if (state_q == ST_IDLE) begin
            if (bus.start) begin
                state_d   = ST_ACQ;
                nco_clr_d = 1'b1;
                acc_clr   = 1'b1;
                good_d    = '0;
                bad_d     = '0;
            end
        end else if (!bus.start) begin
            // stop wins over a window closing in the same cycle
            state_d   = ST_IDLE;
            nco_clr_d = 1'b1;
            acc_clr   = 1'b1;
            good_d    = '0;
            bad_d     = '0;
        end else if (win_done) begin
            vld_d  = 1'b1;
            mean_d = win_mean;
            unique case (state_q)
                ST_ACQ: begin
                    if (good) begin
                        state_d = ST_VERIFY;
                        good_d  = CNT_W'(1);
                    end
`ifdef CSYNC_TIMEOUT_EN
                    else if (int'(to_q) + 1 >= ACQ_TO) begin
                        nco_clr_d = 1'b1;
                        to_d      = '0;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
`endif
                end
                ST_VERIFY: begin
                    if (!good) begin
                        state_d = ST_ACQ;
                        acc_clr = 1'b1;
                        good_d  = '0;
                        bad_d   = '0;
                    end else if (int'(good_q) + 1 >= LOCK_CNT) begin
                        state_d = ST_TRACK;
                        good_d  = '0;
                        bad_d   = '0;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (bad) begin
                        if (int'(bad_q) + 1 >= UNLOCK_CNT) begin
                            state_d   = ST_ACQ;
                            nco_clr_d = 1'b1;
                            acc_clr   = 1'b1;
                            good_d    = '0;
                            bad_d     = '0;
                        end else begin
                            bad_d = bad_q + 1'b1;
                        end
                    end else if (good) begin
                        bad_d = '0;
                    end
                end
                ST_IDLE: ;
            endcase
        end
`ifdef CSYNC_TIMEOUT_EN
        if (state_d != ST_ACQ) to_d = '0;
`endif
        loop_en_d = state_d != ST_IDLE;
        gain_d    = gain_of(state_d);
        locked_d  = state_d == ST_TRACK;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            good_q    <= '0;
            bad_q     <= '0;
            loop_en_q <= 1'b0;
            gain_q    <= GAIN_WIDE;
            nco_clr_q <= 1'b0;
            locked_q  <= 1'b0;
            mean_q    <= '0;
            vld_q     <= 1'b0;
`ifdef CSYNC_TIMEOUT_EN
            to_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            loop_en_q <= loop_en_d;
            gain_q    <= gain_d;
            nco_clr_q <= nco_clr_d;
            locked_q  <= locked_d;
            mean_q    <= mean_d;
            vld_q     <= vld_d;
`ifdef CSYNC_TIMEOUT_EN
            to_q      <= to_d;
`endif
        end
    end

    assign bus.loop_en      = loop_en_q;
    assign bus.gain_sel     = gain_q;
    assign bus.nco_clr      = nco_clr_q;
    assign bus.locked       = locked_q;
    assign bus.state_o      = state_q;
    assign bus.err_mean     = mean_q;
    assign bus.err_mean_vld = vld_q;

endmodule

// File: tb/tb_carrier_lock_ctrl.sv
// Randomized scoreboard bench for carrier_lock_ctrl (16-sample windows).
// Expected window results are queued at issue time and popped by a monitor.
module tb_carrier_lock_ctrl;

    localparam int WL   = 4;
    localparam int WIN  = 16;
    localparam int LTH  = 1200;
    localparam int UTH  = 2400;
    localparam int LCNT = 4;
    localparam int UCNT = 3;
    localparam int ATO  = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    carrier_lock_if bif();

    carrier_lock_ctrl #(
        .WIN_LOG2   (WL),
        .LOCK_TH    (16'(LTH)),
        .UNLOCK_TH  (16'(UTH)),
        .LOCK_CNT   (LCNT),
        .UNLOCK_CNT (UCNT),
        .ACQ_TO     (ATO)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bif)
    );

    typedef struct {
        int mean;
        int st;
        bit clr;
    } exp_t;

    exp_t q[$];
    exp_t e;

    int checks = 0;
    int errors = 0;
    int clr_seen = 0;

    // reference model: state as 0..3, plain integer counters
    int m_st, m_good, m_bad, m_to, m_sum, m_n, m_clr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mag_of(input int x);
        if (x == -32768) return 32767;
        return (x < 0) ? -x : x;
    endfunction

    function automatic int gain_for(input int st);
        if (st == 3) return 0;
        if (st == 2) return 1;
        return 2;
    endfunction

    task automatic model_clear();
        m_sum = 0; m_n = 0; m_good = 0; m_bad = 0; m_to = 0;
    endtask

    task automatic model_window();
        exp_t r;
        int mean;
        bit clr;
        mean = m_sum / WIN;
        clr = 1'b0;
        m_sum = 0;
        m_n = 0;
        if (m_st == 1) begin
            if (mean < LTH) begin
                m_st = 2; m_good = 1; m_to = 0;
            end else begin
`ifdef CSYNC_TIMEOUT_EN
                m_to++;
                if (m_to == ATO) begin clr = 1'b1; m_to = 0; end
`endif
            end
        end else if (m_st == 2) begin
            if (mean < LTH) begin
                m_good++;
                if (m_good >= LCNT) begin m_st = 3; m_bad = 0; end
            end else begin
                m_st = 1; model_clear();
            end
        end else if (m_st == 3) begin
            if (mean > UTH) begin
                m_bad++;
                if (m_bad >= UCNT) begin m_st = 1; clr = 1'b1; model_clear(); end
            end else if (mean < LTH) begin
                m_bad = 0;
            end
        end
        if (clr) m_clr++;
        r.mean = mean;
        r.st = m_st;
        r.clr = clr;
        q.push_back(r);
    endtask

    task automatic send(input int x, input bit stop);
        @(posedge clk); #1;
        bif.phase_error = 16'(x);
        bif.pe_valid = 1'b1;
        if (stop) bif.start = 1'b0;
        if (stop && m_st != 0) begin
            m_st = 0; m_clr++; model_clear();
        end else if (!stop && bif.start && m_st != 0) begin
            m_sum += mag_of(x);
            m_n++;
            if (m_n == WIN) model_window();
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bif.pe_valid = 1'b0;
    endtask

    task automatic do_start();
        @(posedge clk); #1;
        bif.pe_valid = 1'b0;
        bif.start = 1'b1;
        if (m_st == 0) begin
            m_st = 1; m_clr++; model_clear();
        end
    endtask

    function automatic int rnd_signed(input int lo, input int hi);
        int m;
        m = int'($urandom_range(hi, lo));
        return ($urandom_range(1, 0) == 1) ? -m : m;
    endfunction

    task automatic window(input int lo, input int hi, input bit gaps);
        for (int i = 0; i < WIN; i++) begin
            send(rnd_signed(lo, hi), 1'b0);
            if (gaps && $urandom_range(3, 0) == 0) idle();
        end
        idle();
    endtask

    always @(negedge clk) begin
        if (bif.nco_clr) clr_seen++;
        if (bif.err_mean_vld) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_vld: got vld=1 expected none at %0t", $time);
            end else begin
                e = q.pop_front();
                chk("err_mean", int'(bif.err_mean), e.mean);
                chk("state", int'(bif.state_o), e.st);
                chk("locked", int'(bif.locked), int'(e.st == 3));
                chk("gain_sel", int'(bif.gain_sel), gain_for(e.st));
                chk("loop_en", int'(bif.loop_en), 1);
                chk("win_nco_clr", int'(bif.nco_clr), int'(e.clr));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bif.start = 1'b0;
        bif.phase_error = '0;
        bif.pe_valid = 1'b0;
        m_st = 0; m_clr = 0; model_clear();
        #12;
        chk("rst_state", int'(bif.state_o), 0);
        chk("rst_loop_en", int'(bif.loop_en), 0);
        chk("rst_gain", int'(bif.gain_sel), 2);
        chk("rst_nco_clr", int'(bif.nco_clr), 0);
        chk("rst_locked", int'(bif.locked), 0);
        chk("rst_err_mean", int'(bif.err_mean), 0);
        chk("rst_vld", int'(bif.err_mean_vld), 0);
        rst_n = 1'b1;

        // samples while IDLE must be ignored
        for (int i = 0; i < 20; i++) send(rnd_signed(0, 5000), 1'b0);
        idle();

        do_start();
        window(500, 500, 1'b0);
        for (int w = 0; w < 4; w++) window(500, 500, 1'b1);

        // 2 bad + 1 good + 2 bad keeps lock, third consecutive bad drops it
        window(3000, 3000, 1'b0);
        window(3000, 3000, 1'b0);
        window(500, 500, 1'b0);
        window(3000, 3000, 1'b0);
        window(3000, 3000, 1'b0);
        window(3000, 3000, 1'b0);

        for (int i = 0; i < WIN; i++) send(-32768, 1'b0);
        idle();

        for (int w = 0; w < 40; w++) begin
            case ($urandom_range(3, 0))
                0: window(0, 1100, 1'b1);
                1: window(1300, 2300, 1'b1);
                2: window(2600, 6000, 1'b1);
                default: window(0, 32767, 1'b1);
            endcase
        end

        send(100, 1'b1);
        idle();
        do_start();
        for (int w = 0; w < ATO; w++) window(5000, 5000, 1'b0);

        // stop arrives with the closing sample: window discarded
        for (int i = 0; i < WIN - 1; i++) send(rnd_signed(0, 800), 1'b0);
        send(700, 1'b1);
        @(posedge clk); #1;
        bif.pe_valid = 1'b0;
        @(negedge clk);
        chk("stop_state", int'(bif.state_o), m_st);
        chk("stop_loop_en", int'(bif.loop_en), 0);
        chk("stop_gain", int'(bif.gain_sel), 2);
        chk("stop_nco_clr", int'(bif.nco_clr), 1);
        chk("stop_vld", int'(bif.err_mean_vld), 0);

        // async reset mid-window, then a clean window from scratch
        do_start();
        for (int i = 0; i < 7; i++) send(rnd_signed(2000, 9000), 1'b0);
        #3;
        rst_n = 1'b0;
        bif.pe_valid = 1'b0;
        bif.start = 1'b0;
        #1;
        m_st = 0; model_clear();
        chk("arst_state", int'(bif.state_o), 0);
        chk("arst_loop_en", int'(bif.loop_en), 0);
        chk("arst_gain", int'(bif.gain_sel), 2);
        chk("arst_err_mean", int'(bif.err_mean), 0);
        #10;
        rst_n = 1'b1;
        do_start();
        window(500, 500, 1'b1);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("nco_clr_pulses", clr_seen, m_clr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
